// File: rtl/control_defs.sv
// ---------------------------------------------------------------------------
// control_defs
// Shared definitions for the phase-1 control sequencer, its decoder and the
// benches that drive it: state encodings, opcode constants, IR field
// positions and the packed strobe vector handed from decoder to top.
// ---------------------------------------------------------------------------
package control_defs;

   // Binary-encoded sequencer states.
   typedef enum logic [2:0] {
      ST_T0   = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_T4   = 3'd4,
      ST_T5   = 3'd5,
      ST_HALT = 3'd6
   } state_t;

   // Opcode constants: halt opcode and the top of the three-register ALU range.
   localparam logic [4:0] OPC_HALT_DEF   = 5'b11010;
   localparam logic [4:0] ALU_OP_MAX_DEF = 5'b01011;
   localparam logic [4:0] OPC_NOP        = 5'b11111;

   // IR field bit positions.
   localparam int IR_OPC_MSB = 31;
   localparam int IR_OPC_LSB = 27;
   localparam int IR_RA_MSB  = 26;
   localparam int IR_RA_LSB  = 23;
   localparam int IR_RB_MSB  = 22;
   localparam int IR_RB_LSB  = 19;
   localparam int IR_RC_MSB  = 18;
   localparam int IR_RC_LSB  = 15;

   // Every datapath strobe plus the ALU select, in one packed vector.
   typedef struct packed {
      logic       pc_out;
      logic       mar_in;
      logic       z_in;
      logic       zlo_out;
      logic       pc_in;
      logic       increment_pc;
      logic       read;
      logic       mdr_in;
      logic       mdr_out;
      logic       ir_in;
      logic       y_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic [4:0] alu_control;
   } strobes_t;

   localparam int       STROBE_W     = $bits(strobes_t);
   localparam strobes_t STROBES_NONE = '0;

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational map from sequencer state and opcode to the strobe
// vector. Also classifies the opcode so the top can pick the T3 successor.
// Ports:
//   state      - current sequencer state (control_defs::state_t encoding)
//   run        - Run input; gates the T0 strobes
//   opcode     - IR[31:27]
//   strobes    - packed control_defs::strobes_t vector
//   op_is_alu  - opcode lies in the three-register ALU range
//   op_is_halt - opcode is the halt opcode
// ---------------------------------------------------------------------------
module control_decode
   import control_defs::*;
#(
   parameter logic [4:0] OPC_HALT   = OPC_HALT_DEF,
   parameter logic [4:0] ALU_OP_MAX = ALU_OP_MAX_DEF
) (
   input  logic [2:0]          state,
   input  logic                run,
   input  logic [4:0]          opcode,
   output logic [STROBE_W-1:0] strobes,
   output logic                op_is_alu,
   output logic                op_is_halt
);

   strobes_t s;

   assign op_is_alu  = (opcode <= ALU_OP_MAX);
   assign op_is_halt = (opcode == OPC_HALT);

   always_comb begin
      s = STROBES_NONE;
      case (state_t'(state))
         ST_T0: begin
            // Idle T0 holds every strobe low until Run allows a fetch.
            if (run) begin
               s.pc_out = 1'b1;
               s.mar_in = 1'b1;
               s.z_in   = 1'b1;
            end
         end
         ST_T1: begin
            s.zlo_out      = 1'b1;
            s.pc_in        = 1'b1;
            s.increment_pc = 1'b1;
            s.read         = 1'b1;
            s.mdr_in       = 1'b1;
         end
         ST_T2: begin
            s.mdr_out = 1'b1;
            s.ir_in   = 1'b1;
         end
         ST_T3: begin
            // Halt and NOP opcodes decode silently.
            if (op_is_alu) begin
               s.grb   = 1'b1;
               s.r_out = 1'b1;
               s.y_in  = 1'b1;
            end
         end
         ST_T4: begin
            s.grc         = 1'b1;
            s.r_out       = 1'b1;
            s.z_in        = 1'b1;
            s.alu_control = opcode;
         end
         ST_T5: begin
            s.zlo_out = 1'b1;
            s.gra     = 1'b1;
            s.r_in    = 1'b1;
         end
         default: ;
      endcase
   end

   assign strobes = s;

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit for the phase-1 datapath: fetch, decode and
// three-register ALU execute, plus a sticky halt and a completed-ALU counter.
// Ports:
//   Clock, Resetn       - clock, synchronous active-low reset
//   Run                 - permits a new instruction (looked at in T0 only)
//   IR                  - instruction register (opcode in IR[31:27])
//   PCout..Yin, Gra/Grb/Grc, Rin/Rout - datapath strobes
//   ALUControl          - ALU operation select (nonzero only in T4)
//   Halted              - sticky halt flag
//   InstrCount          - completed ALU instructions, wraps at 16 bits
// ---------------------------------------------------------------------------
module control_sequencer
   import control_defs::*;
#(
   parameter logic [4:0] OPC_HALT   = OPC_HALT_DEF,
   parameter logic [4:0] ALU_OP_MAX = ALU_OP_MAX_DEF
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Run,
   input  logic [31:0] IR,
   output logic        PCout,
   output logic        MARin,
   output logic        Zin,
   output logic        ZLOout,
   output logic        PCin,
   output logic        IncrementPC,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic [4:0]  ALUControl,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        Halted,
   output logic [15:0] InstrCount
);

   state_t      state_q, state_d;
   logic        halted_q, halted_d;
   logic [15:0] instr_count_q, instr_count_d;

   logic [STROBE_W-1:0] dec_strobes;
   logic                op_is_alu;
   logic                op_is_halt;
   strobes_t            s;

   // Only the opcode field steers the sequencer; register fields go elsewhere.
   logic unused_ir_fields;
   assign unused_ir_fields = ^IR[IR_RA_MSB:0];

   control_decode #(
      .OPC_HALT   (OPC_HALT),
      .ALU_OP_MAX (ALU_OP_MAX)
   ) u_decode (
      .state      (state_q),
      .run        (Run),
      .opcode     (IR[IR_OPC_MSB:IR_OPC_LSB]),
      .strobes    (dec_strobes),
      .op_is_alu  (op_is_alu),
      .op_is_halt (op_is_halt)
   );

   always_comb begin
      state_d       = state_q;
      halted_d      = halted_q;
      instr_count_d = instr_count_q;
      case (state_q)
         ST_T0: if (Run) state_d = ST_T1;
         ST_T1: state_d = ST_T2;
         ST_T2: state_d = ST_T3;
         ST_T3: begin
            if (op_is_alu) begin
               state_d = ST_T4;
            end else if (op_is_halt) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = ST_T0;
            end
         end
         ST_T4: state_d = ST_T5;
         ST_T5: begin
            state_d       = ST_T0;
            instr_count_d = instr_count_q + 16'd1;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_T0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q       <= ST_T0;
         halted_q      <= 1'b0;
         instr_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         halted_q      <= halted_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Strobes are held low for as long as Resetn is low, whatever the state.
   assign s = Resetn ? strobes_t'(dec_strobes) : STROBES_NONE;

   assign PCout       = s.pc_out;
   assign MARin       = s.mar_in;
   assign Zin         = s.z_in;
   assign ZLOout      = s.zlo_out;
   assign PCin        = s.pc_in;
   assign IncrementPC = s.increment_pc;
   assign Read        = s.read;
   assign MDRin       = s.mdr_in;
   assign MDRout      = s.mdr_out;
   assign IRin        = s.ir_in;
   assign Yin         = s.y_in;
   assign ALUControl  = s.alu_control;
   assign Gra         = s.gra;
   assign Grb         = s.grb;
   assign Grc         = s.grc;
   assign Rin         = s.r_in;
   assign Rout        = s.r_out;
   assign Halted      = halted_q;
   assign InstrCount  = instr_count_q;

endmodule
